// File: rtl/or_quad_scheduler.sv
// Round-robin packer that shares one quad 2-input OR package among NREQ requesters.
// Grant and package drive are combinational; results register one cycle after the grant.
// Requesters stall while req_ready is low; responses cannot be stalled.
module or_quad_scheduler #(
  parameter int NREQ  = 4,
  parameter int LANES = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [2*NREQ-1:0]   req_w,
  input  logic [4*NREQ-1:0]   req_a,
  input  logic [4*NREQ-1:0]   req_b,
  output logic [LANES-1:0]    chip_a,
  output logic [LANES-1:0]    chip_b,
  input  logic [LANES-1:0]    chip_y,
  output logic [NREQ-1:0]     rsp_valid,
  output logic [4*NREQ-1:0]   rsp_y
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0]     ptr_q, ptr_d;
  logic [NREQ-1:0]   rsp_valid_q, rsp_valid_d;
  logic [4*NREQ-1:0] rsp_y_q, rsp_y_d;

  logic [NREQ-1:0]   grant;
  logic [PW-1:0]     last_idx;
  logic [1:0]        w_arr    [NREQ];
  logic [3:0]        a_arr    [NREQ];
  logic [3:0]        b_arr    [NREQ];
  logic [3:0]        off_arr  [NREQ];
  logic [3:0]        mask_arr [NREQ];

  // Unpack the flat request buses into per-requester fields.
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      w_arr[i] = req_w[2*i +: 2];
      a_arr[i] = req_a[4*i +: 4];
      b_arr[i] = req_b[4*i +: 4];
    end
  end

  // Single scan from ptr: pack valid requests into lanes until one does not fit.
  always_comb begin : scan
    logic [PW:0]   sum;
    logic [PW-1:0] idx;
    logic [2:0]    wl;
    logic [3:0]    used;
    logic [3:0]    mask;
    logic          stop;
    grant    = '0;
    chip_a   = '0;
    chip_b   = '0;
    last_idx = ptr_q;
    used     = '0;
    stop     = 1'b0;
    sum      = '0;
    idx      = '0;
    wl       = '0;
    mask     = '0;
    for (int i = 0; i < NREQ; i++) begin
      off_arr[i]  = '0;
      mask_arr[i] = '0;
    end
    for (int s = 0; s < NREQ; s++) begin
      // Scan position s maps to requester (ptr + s) mod NREQ.
      sum = {1'b0, ptr_q} + (PW+1)'(s);
      if (sum >= (PW+1)'(NREQ)) sum = sum - (PW+1)'(NREQ);
      idx  = sum[PW-1:0];
      wl   = {1'b0, w_arr[idx]} + 3'd1;
      mask = ~(4'hF << wl);
      if (!stop && !rst && req_valid[idx]) begin
        if (used + {1'b0, wl} <= 4'(LANES)) begin
          grant[idx]    = 1'b1;
          off_arr[idx]  = used;
          mask_arr[idx] = mask;
          chip_a        = chip_a | ((a_arr[idx] & mask) << used);
          chip_b        = chip_b | ((b_arr[idx] & mask) << used);
          used          = used + {1'b0, wl};
          last_idx      = idx;
        end else begin
          // No skipping: the first request that does not fit ends the scan.
          stop = 1'b1;
        end
      end
    end
  end

  assign req_ready = grant;

  // Next state: capture each granted slice of chip_y and advance the pointer.
  always_comb begin
    ptr_d       = ptr_q;
    rsp_valid_d = grant;
    rsp_y_d     = rsp_y_q;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) rsp_y_d[4*i +: 4] = (chip_y >> off_arr[i]) & mask_arr[i];
    end
    if (|grant) ptr_d = (last_idx == PW'(NREQ-1)) ? '0 : last_idx + 1'b1;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q       <= '0;
      rsp_valid_q <= '0;
      rsp_y_q     <= '0;
    end else begin
      ptr_q       <= ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_y_q     <= rsp_y_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_y     = rsp_y_q;

endmodule
